// File: rtl/safe_wrapper_seq_pkg.sv
// Shared types and constants for the safe-wrapper mode sequencer.
package safe_wrapper_seq_pkg;

  // Storage width for a master-core index; covers up to 256 cores.
  localparam int CORE_IDX_MAX_W = 8;

  // Configuration encoding that must never be applied to the cores.
  localparam logic [1:0] SAFE_CFG_RESERVED = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Field order matters: the top builds this struct by concatenation.
  typedef struct packed {
    logic [CORE_IDX_MAX_W-1:0] master_core;
    logic                      safe_mode;
    logic [1:0]                safe_cfg;
    logic                      critical;
  } safe_cfg_t;

  function automatic logic cfg_is_reserved(input logic [1:0] cfg);
    return cfg == SAFE_CFG_RESERVED;
  endfunction

endpackage

// File: rtl/safe_wrapper_edge_det.sv
// Single-bit rise/fall pulse generator with one register of history.
module safe_wrapper_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Remember the previous sample of the input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/safe_wrapper_mode_sequencer.sv
// Safe-wrapper mode sequencer: picks external or bus-programmed safety config,
// validates it and walks the cores through start -> sync -> run -> end.
module safe_wrapper_mode_sequencer
  import safe_wrapper_seq_pkg::*;
#(
  parameter int NCORES       = 3,
  parameter int CORE_IDX_W   = $clog2(NCORES),
  parameter int SYNC_TIMEOUT = 1024,
  parameter int CNT_W        = $clog2(SYNC_TIMEOUT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CORE_IDX_W-1:0] ext_master_core_i,
  input  logic                  ext_safe_mode_i,
  input  logic [1:0]            ext_safe_cfg_i,
  input  logic                  ext_critical_i,
  input  logic                  ext_start_i,
  input  logic [CORE_IDX_W-1:0] reg_master_core_i,
  input  logic                  reg_safe_mode_i,
  input  logic [1:0]            reg_safe_cfg_i,
  input  logic                  reg_critical_i,
  input  logic                  end_sw_i,
  input  logic [NCORES-1:0]     sync_ack_i,
  output logic [CORE_IDX_W-1:0] master_core_o,
  output logic                  safe_mode_o,
  output logic [1:0]            safe_cfg_o,
  output logic                  critical_o,
  output logic                  cfg_capture_de_o,
  output logic                  end_sw_clear_o,
  output logic [NCORES-1:0]     sync_req_o,
  output logic                  start_o,
  output logic                  busy_o,
  output logic                  cfg_err_o,
  output logic                  timeout_o
);

  localparam logic [CORE_IDX_W:0] NCORES_L  = (CORE_IDX_W + 1)'(NCORES);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SYNC_TIMEOUT - 1);

  state_e            state, state_next;
  safe_cfg_t         cfg_q, cfg_next;
  safe_cfg_t         ext_cfg, reg_cfg;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              cfg_err_q, cfg_err_next;
  logic              timeout_q, timeout_next;
  logic              clear_q, clear_next;
  logic              start_rise, start_fall;
  logic              end_rise;
  logic              unused_end_fall;  // falling edge of end_sw_i carries no meaning here
  logic              ext_valid;
  logic [NCORES-1:0] one_hot, need;

  safe_wrapper_edge_det u_start_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (ext_start_i),
    .rise_o (start_rise),
    .fall_o (start_fall)
  );

  safe_wrapper_edge_det u_end_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (end_sw_i),
    .rise_o (end_rise),
    .fall_o (unused_end_fall)
  );

  assign ext_cfg = {CORE_IDX_MAX_W'(ext_master_core_i), ext_safe_mode_i,
                    ext_safe_cfg_i, ext_critical_i};
  assign reg_cfg = {CORE_IDX_MAX_W'(reg_master_core_i), reg_safe_mode_i,
                    reg_safe_cfg_i, reg_critical_i};

  // Only the external source is validated; it is what gets checked at start.
  assign ext_valid = ({1'b0, ext_master_core_i} < NCORES_L) && !cfg_is_reserved(ext_safe_cfg_i);

  // Lockstep needs every core in sync; split mode only the master.
  assign one_hot = {{(NCORES-1){1'b0}}, 1'b1} << cfg_q.master_core;
  assign need    = cfg_q.safe_mode ? {NCORES{1'b1}} : one_hot;

  // Register all sequencer state; reset wipes everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cfg_q     <= '0;
      cnt       <= '0;
      cfg_err_q <= 1'b0;
      timeout_q <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_q     <= cfg_next;
      cnt       <= cnt_next;
      cfg_err_q <= cfg_err_next;
      timeout_q <= timeout_next;
      clear_q   <= clear_next;
    end
  end

  // Next-state, config source selection, sync timeout and sticky errors.
  always_comb begin
    state_next   = state;
    cfg_next     = cfg_q;
    cnt_next     = cnt;
    cfg_err_next = cfg_err_q;
    timeout_next = timeout_q;
    clear_next   = 1'b0;
    case (state)
      IDLE: begin
        cfg_next = ext_cfg;
        if (start_rise) begin
          if (ext_valid) begin
            state_next   = SYNC;
            cnt_next     = '0;
            cfg_err_next = 1'b0;
            timeout_next = 1'b0;
          end else begin
            state_next   = ERR;
            cfg_err_next = 1'b1;
          end
        end
      end
      SYNC: begin
        // Dropping start aborts ahead of ack and timeout.
        if (start_fall) begin
          state_next = IDLE;
        end else if ((sync_ack_i & need) == need) begin
          state_next = RUN;
        end else if (cnt == CNT_LAST) begin
          state_next   = ERR;
          timeout_next = 1'b1;
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (start_fall) begin
          state_next = IDLE;
        end else begin
          if (end_rise) begin
            state_next = DONE;
            clear_next = 1'b1;
          end
          // While critical, config is frozen; only clearing the flag can unlock.
          if (cfg_q.critical) begin
            if (!reg_critical_i) begin
              cfg_next.critical = 1'b0;
            end
          end else begin
            cfg_next = reg_cfg;
          end
        end
      end
      DONE: begin
        if (!ext_start_i) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        if (!ext_start_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign master_core_o    = cfg_q.master_core[CORE_IDX_W-1:0];
  assign safe_mode_o      = cfg_q.safe_mode;
  assign safe_cfg_o       = cfg_q.safe_cfg;
  assign critical_o       = cfg_q.critical;
  assign cfg_capture_de_o = (state == IDLE) && !rst_i;
  assign end_sw_clear_o   = clear_q;
  assign sync_req_o       = (state == SYNC) ? need : '0;
  assign start_o          = (state == RUN);
  assign busy_o           = (state != IDLE);
  assign cfg_err_o        = cfg_err_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_safe_wrapper_mode_sequencer.sv
// Directed bench for the safe-wrapper mode sequencer (3 cores, 8-cycle sync timeout).
module tb_safe_wrapper_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ext_master_core = '0;
  logic       ext_safe_mode = 1'b0;
  logic [1:0] ext_safe_cfg = '0;
  logic       ext_critical = 1'b0;
  logic       ext_start = 1'b0;
  logic [1:0] reg_master_core = '0;
  logic       reg_safe_mode = 1'b0;
  logic [1:0] reg_safe_cfg = '0;
  logic       reg_critical = 1'b0;
  logic       end_sw = 1'b0;
  logic [2:0] sync_ack = '0;
  logic [1:0] master_core;
  logic       safe_mode;
  logic [1:0] safe_cfg;
  logic       critical;
  logic       cfg_capture_de;
  logic       end_sw_clear;
  logic [2:0] sync_req;
  logic       start;
  logic       busy;
  logic       cfg_err;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  safe_wrapper_mode_sequencer #(
    .NCORES       (3),
    .SYNC_TIMEOUT (8)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ext_master_core_i (ext_master_core),
    .ext_safe_mode_i   (ext_safe_mode),
    .ext_safe_cfg_i    (ext_safe_cfg),
    .ext_critical_i    (ext_critical),
    .ext_start_i       (ext_start),
    .reg_master_core_i (reg_master_core),
    .reg_safe_mode_i   (reg_safe_mode),
    .reg_safe_cfg_i    (reg_safe_cfg),
    .reg_critical_i    (reg_critical),
    .end_sw_i          (end_sw),
    .sync_ack_i        (sync_ack),
    .master_core_o     (master_core),
    .safe_mode_o       (safe_mode),
    .safe_cfg_o        (safe_cfg),
    .critical_o        (critical),
    .cfg_capture_de_o  (cfg_capture_de),
    .end_sw_clear_o    (end_sw_clear),
    .sync_req_o        (sync_req),
    .start_o           (start),
    .busy_o            (busy),
    .cfg_err_o         (cfg_err),
    .timeout_o         (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ext(input logic [1:0] m, input logic sm, input logic [1:0] c, input logic cr);
    ext_master_core = m;
    ext_safe_mode   = sm;
    ext_safe_cfg    = c;
    ext_critical    = cr;
  endtask

  initial begin
    // Reset state
    tick(2);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_capture", 32'(cfg_capture_de), 0);
    check_val("rst_outs", 32'({master_core, safe_mode, safe_cfg, critical, end_sw_clear,
                               sync_req, start, cfg_err, timeout}), 0);
    rst = 1'b0;
    tick(1);
    check_val("idle_capture", 32'(cfg_capture_de), 1);

    // 1: lockstep, master 1, cfg 01, critical; acks after 3 SYNC cycles
    set_ext(2'd1, 1'b1, 2'b01, 1'b1);
    tick(1);
    check_val("t1_cfg_master", 32'(master_core), 1);
    check_val("t1_cfg_safecfg", 32'(safe_cfg), 1);
    ext_start = 1'b1;
    tick(1);
    check_val("t1_sync_req", 32'(sync_req), 7);
    check_val("t1_capture_off", 32'(cfg_capture_de), 0);
    tick(2);
    check_val("t1_still_sync_start", 32'(start), 0);
    check_val("t1_still_sync_req", 32'(sync_req), 7);
    sync_ack = 3'b111;
    tick(1);
    sync_ack = 3'b000;
    check_val("t1_run_start", 32'(start), 1);
    check_val("t1_run_req", 32'(sync_req), 0);

    // 5: critical lock holds config until the bus clears critical
    reg_master_core = 2'd1;
    reg_safe_mode   = 1'b1;
    reg_safe_cfg    = 2'b10;
    reg_critical    = 1'b1;
    tick(2);
    check_val("t5_locked_cfg", 32'(safe_cfg), 1);
    check_val("t5_locked_crit", 32'(critical), 1);
    reg_critical = 1'b0;
    tick(3);
    check_val("t5_unlocked_cfg", 32'(safe_cfg), 2);
    check_val("t5_unlocked_crit", 32'(critical), 0);

    // 6a: end_sw rise -> DONE with a single clear pulse
    end_sw = 1'b1;
    tick(1);
    check_val("t6_clear_pulse", 32'(end_sw_clear), 1);
    check_val("t6_done_start", 32'(start), 0);
    check_val("t6_done_busy", 32'(busy), 1);
    end_sw = 1'b0;
    tick(1);
    check_val("t6_clear_once", 32'(end_sw_clear), 0);
    ext_start = 1'b0;
    tick(1);
    check_val("t6_idle_busy", 32'(busy), 0);

    // 2: split mode, master 2; only core 2's ack matters
    set_ext(2'd2, 1'b0, 2'b00, 1'b0);
    tick(1);
    ext_start = 1'b1;
    tick(1);
    check_val("t2_sync_req", 32'(sync_req), 4);
    sync_ack = 3'b001;
    tick(2);
    check_val("t2_wrong_ack_req", 32'(sync_req), 4);
    check_val("t2_wrong_ack_start", 32'(start), 0);
    sync_ack = 3'b100;
    tick(1);
    check_val("t2_run_start", 32'(start), 1);
    sync_ack = 3'b000;
    ext_start = 1'b0;
    tick(1);
    check_val("t2_abort_busy", 32'(busy), 0);
    check_val("t2_abort_start", 32'(start), 0);

    // 3: no acks -> timeout after 8 SYNC cycles
    ext_start = 1'b1;
    tick(1);
    tick(7);
    check_val("t3_sync_at_7", 32'(sync_req), 4);
    check_val("t3_no_timeout_yet", 32'(timeout), 0);
    tick(1);
    check_val("t3_timeout", 32'(timeout), 1);
    check_val("t3_err_req", 32'(sync_req), 0);
    check_val("t3_err_busy", 32'(busy), 1);
    ext_start = 1'b0;
    tick(1);
    check_val("t3_idle_busy", 32'(busy), 0);
    check_val("t3_timeout_sticky", 32'(timeout), 1);

    // 4: reserved cfg and out-of-range master both go straight to ERR
    set_ext(2'd0, 1'b0, 2'b11, 1'b0);
    tick(1);
    ext_start = 1'b1;
    tick(1);
    check_val("t4_resv_err", 32'(cfg_err), 1);
    check_val("t4_resv_busy", 32'(busy), 1);
    tick(1);
    check_val("t4_resv_req", 32'(sync_req), 0);
    ext_start = 1'b0;
    tick(1);
    set_ext(2'd3, 1'b0, 2'b00, 1'b0);
    tick(1);
    ext_start = 1'b1;
    tick(1);
    check_val("t4_m3_err", 32'(cfg_err), 1);
    check_val("t4_m3_req", 32'(sync_req), 0);
    check_val("t4_m3_start", 32'(start), 0);
    ext_start = 1'b0;
    tick(1);

    // Valid start clears sticky errors; 6b: start fall with ack aborts
    set_ext(2'd0, 1'b0, 2'b00, 1'b0);
    tick(1);
    ext_start = 1'b1;
    tick(1);
    check_val("clr_cfg_err", 32'(cfg_err), 0);
    check_val("clr_timeout", 32'(timeout), 0);
    check_val("t6b_sync_req", 32'(sync_req), 1);
    sync_ack  = 3'b001;
    ext_start = 1'b0;
    tick(1);
    check_val("t6b_abort_busy", 32'(busy), 0);
    check_val("t6b_abort_start", 32'(start), 0);
    check_val("t6b_no_clear", 32'(end_sw_clear), 0);
    sync_ack = 3'b000;

    // Reset asserted mid-run returns everything to zero at once
    ext_start = 1'b1;
    tick(1);
    sync_ack = 3'b001;
    tick(1);
    check_val("mid_run_start", 32'(start), 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_start", 32'(start), 0);
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_clear", 32'(end_sw_clear), 0);
    ext_start = 1'b0;
    sync_ack  = 3'b000;
    tick(1);
    rst = 1'b0;
    tick(1);
    check_val("post_rst_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
